dual_rank_mem_ctrl: RTL and testbench

Controller that sequences two RAMB128x8 ranks as one 256x8 memory for a single requester.
- After reset it optionally initialises both ranks.
- It then accepts one read or write request at a time over a valid/ready handshake and returns read data with a response pulse.
- Sits between the system requester and the two rank instances in the dual-rank top level. The ranks are instantiated in the top level, not here.

---
 rtl/dual_rank_pkg.sv | 23 ++
 rtl/dual_rank_mem_ctrl.sv | 134 +++++++++++++
 tb/tb_dual_rank_mem_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dual_rank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dual_rank_pkg
// Purpose  : Shared state encoding and default widths for the dual-rank
//            memory controller.
// Revision : 1.0
// ============================================================================
package dual_rank_pkg;

  localparam int c_WORDADDR_WIDTH = 7;
  localparam int c_DATA_WIDTH     = 8;
  localparam int c_ADDR_WIDTH     = c_WORDADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dual_rank_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dual_rank_mem_ctrl
// Purpose  : Presents two 128x8 ranks as one 256x8 memory; optional fill on
//            reset, one read or write in flight at a time.
// Revision : 1.0
// ============================================================================
module dual_rank_mem_ctrl
  import dual_rank_pkg::*;
#(
  parameter int                     WORDADDR_WIDTH = c_WORDADDR_WIDTH,
  parameter int                     DATA_WIDTH     = c_DATA_WIDTH,
  parameter int                     INIT_ON_RESET  = 1,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE     = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [WORDADDR_WIDTH:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      init_done,
  output logic                      rank0_cs,
  output logic                      rank1_cs,
  output logic                      ram_wr,
  output logic [WORDADDR_WIDTH-1:0] ram_wordAddr,
  output logic [DATA_WIDTH-1:0]     ram_dataIn,
  input  logic [DATA_WIDTH-1:0]     rank0_dataOut,
  input  logic [DATA_WIDTH-1:0]     rank1_dataOut
);

  localparam logic [WORDADDR_WIDTH-1:0] c_LAST_WORD = '1;

  state_t                    r_state;
  state_t                    w_nextState;
  logic [WORDADDR_WIDTH-1:0] r_initCnt;
  logic [WORDADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      r_rank;
  logic                      r_initDone;
  logic                      w_accept;

  // Ready waits for r_initDone so it stays low while reset is asserted.
  assign req_ready = (r_state == ST_IDLE) && r_initDone;
  assign w_accept  = req_valid && req_ready;
  assign init_done = r_initDone;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    rank0_cs     = 1'b0;
    rank1_cs     = 1'b0;
    ram_wr       = 1'b0;
    ram_wordAddr = r_addr;
    ram_dataIn   = r_data;
    case (r_state)
      ST_INIT: begin
        rank0_cs     = 1'b1;
        rank1_cs     = 1'b1;
        ram_wr       = 1'b1;
        ram_wordAddr = r_initCnt;
        ram_dataIn   = INIT_VALUE;
        if (r_initCnt == c_LAST_WORD) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_accept) begin
          w_nextState = req_wr ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        rank0_cs    = !r_rank;
        rank1_cs    = r_rank;
        ram_wr      = 1'b1;
        w_nextState = ST_IDLE;
      end
      ST_READ: begin
        rank0_cs    = !r_rank;
        rank1_cs    = r_rank;
        w_nextState = ST_RESP;
      end
      ST_RESP: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_initCnt  <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rank     <= 1'b0;
      r_initDone <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= (r_state == ST_RESP);
      if (r_state == ST_RESP) begin
        resp_rdata <= r_rank ? rank1_dataOut : rank0_dataOut;
      end
      if (w_nextState != ST_INIT) begin
        r_initDone <= 1'b1;
      end
      // Track the fill address so the shared bus holds its last value in IDLE.
      if (r_state == ST_INIT) begin
        r_initCnt <= r_initCnt + 1'b1;
        r_addr    <= r_initCnt;
        r_data    <= INIT_VALUE;
      end
      if (w_accept) begin
        r_addr <= req_addr[WORDADDR_WIDTH-1:0];
        r_data <= req_wdata;
        r_rank <= req_addr[WORDADDR_WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dual_rank_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_rank_mem_ctrl
// Purpose  : Directed self-checking bench; models both ranks for an
//            init-on-reset build and a no-init build of the controller.
// Revision : 1.0
// ============================================================================
module tb_dual_rank_mem_ctrl;

  logic       clk;
  logic       rstN, rstBN;
  int         nChecks, nFails;

  // Build A: INIT_ON_RESET=1
  logic       reqValid, reqReady, reqWr, respValid, initDone;
  logic [7:0] reqAddr, reqWdata, respRdata;
  logic       rank0Cs, rank1Cs, ramWr;
  logic [6:0] ramWordAddr;
  logic [7:0] ramDataIn, a0Out, a1Out;
  logic [7:0] memA0 [128];
  logic [7:0] memA1 [128];

  // Build B: INIT_ON_RESET=0
  logic       bValid, bReady, bWr, bRespValid, bInitDone;
  logic [7:0] bAddr, bWdata, bRespRdata;
  logic       bCs0, bCs1, bRamWr;
  logic [6:0] bWordAddr;
  logic [7:0] bDataIn, b0Out, b1Out;
  logic [7:0] memB0 [128];
  logic [7:0] memB1 [128];

  dual_rank_mem_ctrl #(.INIT_ON_RESET(1), .INIT_VALUE(8'h00)) dutA (
    .clk(clk), .rst_n(rstN),
    .req_valid(reqValid), .req_ready(reqReady), .req_wr(reqWr),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(respValid), .resp_rdata(respRdata), .init_done(initDone),
    .rank0_cs(rank0Cs), .rank1_cs(rank1Cs), .ram_wr(ramWr),
    .ram_wordAddr(ramWordAddr), .ram_dataIn(ramDataIn),
    .rank0_dataOut(a0Out), .rank1_dataOut(a1Out)
  );

  dual_rank_mem_ctrl #(.INIT_ON_RESET(0), .INIT_VALUE(8'h00)) dutB (
    .clk(clk), .rst_n(rstBN),
    .req_valid(bValid), .req_ready(bReady), .req_wr(bWr),
    .req_addr(bAddr), .req_wdata(bWdata),
    .resp_valid(bRespValid), .resp_rdata(bRespRdata), .init_done(bInitDone),
    .rank0_cs(bCs0), .rank1_cs(bCs1), .ram_wr(bRamWr),
    .ram_wordAddr(bWordAddr), .ram_dataIn(bDataIn),
    .rank0_dataOut(b0Out), .rank1_dataOut(b1Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rank models: write on cs&wr, registered read data on cs&!wr
  always @(posedge clk) begin
    if (rank0Cs) begin if (ramWr) memA0[ramWordAddr] <= ramDataIn; else a0Out <= memA0[ramWordAddr]; end
    if (rank1Cs) begin if (ramWr) memA1[ramWordAddr] <= ramDataIn; else a1Out <= memA1[ramWordAddr]; end
    if (bCs0) begin if (bRamWr) memB0[bWordAddr] <= bDataIn; else b0Out <= memB0[bWordAddr]; end
    if (bCs1) begin if (bRamWr) memB1[bWordAddr] <= bDataIn; else b1Out <= memB1[bWordAddr]; end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    int n = 0;
    while (!reqReady && n < 400) begin
      step();
      n++;
    end
    if (!reqReady) checkVal("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic doWrite(input logic [7:0] addr, input logic [7:0] data);
    reqValid = 1'b1; reqWr = 1'b1; reqAddr = addr; reqWdata = data;
    waitReady();
    step();
    reqValid = 1'b0; reqAddr = ~addr; reqWdata = ~data;
    checkVal("wr_bus", {rank0Cs, rank1Cs, ramWr, ramWordAddr, ramDataIn},
             {!addr[7], addr[7], 1'b1, addr[6:0], data});
    checkVal("wr_busy", reqReady, 1'b0);
    step();
  endtask

  // Accept edge counts as the first edge; response is visible after the third.
  task automatic doRead(input logic [7:0] addr, input logic [7:0] exp);
    reqValid = 1'b1; reqWr = 1'b0; reqAddr = addr; reqWdata = 8'hFF;
    waitReady();
    step();
    reqValid = 1'b0; reqAddr = ~addr;
    checkVal("rd_bus", {rank0Cs, rank1Cs, ramWr, ramWordAddr}, {!addr[7], addr[7], 1'b0, addr[6:0]});
    checkVal("rd_early", respValid, 1'b0);
    step();
    checkVal("rd_resp_state", {respValid, rank0Cs, rank1Cs, reqReady}, 4'b0000);
    step();
    checkVal("rd_valid", {respValid, reqReady}, 2'b11);
    checkVal("rd_data", respRdata, exp);
    step();
    checkVal("rd_pulse_end", respValid, 1'b0);
    checkVal("rd_data_hold", respRdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int good;
    int pulses;
    nChecks = 0; nFails = 0;
    rstN = 1'b0; rstBN = 1'b0;
    reqValid = 1'b0; reqWr = 1'b0; reqAddr = '0; reqWdata = '0;
    bValid = 1'b0; bWr = 1'b0; bAddr = '0; bWdata = '0;
    for (int i = 0; i < 128; i++) begin
      memA0[i] = 8'hEE; memA1[i] = 8'hEE; memB0[i] = 8'h00; memB1[i] = 8'h00;
    end
    step(); step(); step();

    // 1: reset state, then 128-cycle fill of both ranks
    checkVal("rst_state", {respValid, respRdata, initDone, reqReady}, 11'd0);
    rstN = 1'b1;
    good = 0;
    for (int i = 0; i < 128; i++) begin
      if (rank0Cs && rank1Cs && ramWr && !reqReady && !initDone &&
          ramWordAddr == 7'(i) && ramDataIn == 8'h00) good++;
      step();
    end
    checkVal("init_cycles", good, 128);
    checkVal("init_done", {initDone, reqReady, rank0Cs, rank1Cs}, 4'b1100);
    doRead(8'h05, 8'h00);
    doRead(8'hC3, 8'h00);

    // 2, 3: independent ranks
    doWrite(8'h12, 8'hA5);
    doRead(8'h12, 8'hA5);
    doWrite(8'h92, 8'h3C);
    doRead(8'h12, 8'hA5);
    doRead(8'h92, 8'h3C);

    // 4: back-to-back writes across the rank boundary
    reqValid = 1'b1; reqWr = 1'b1; reqAddr = 8'h7F; reqWdata = 8'h11;
    waitReady();
    step();
    checkVal("b2b_wr0", {rank0Cs, rank1Cs, ramWr, ramWordAddr, ramDataIn}, {3'b101, 7'h7F, 8'h11});
    checkVal("b2b_busy", reqReady, 1'b0);
    reqAddr = 8'h80; reqWdata = 8'h22;
    step();
    checkVal("b2b_ready", reqReady, 1'b1);
    step();
    checkVal("b2b_wr1", {rank0Cs, rank1Cs, ramWr, ramWordAddr, ramDataIn}, {3'b011, 7'h00, 8'h22});
    reqValid = 1'b0;
    step();
    doRead(8'h7F, 8'h11);
    doRead(8'h80, 8'h22);

    // 5: reset while a read is in READ
    reqValid = 1'b1; reqWr = 1'b0; reqAddr = 8'h12;
    waitReady();
    step();
    reqValid = 1'b0;
    checkVal("mid_read_cs", {rank0Cs, rank1Cs}, 2'b10);
    rstN = 1'b0;
    #1;
    checkVal("mid_rst_state", {respValid, respRdata, initDone, reqReady}, 11'd0);
    step(); step();
    rstN = 1'b1;
    pulses = 0;
    for (int i = 0; i < 300 && !initDone; i++) begin
      if (respValid) pulses++;
      step();
    end
    checkVal("mid_rst_no_resp", pulses, 0);
    checkVal("mid_rst_reinit", {initDone, respRdata}, {1'b1, 8'h00});
    doRead(8'h12, 8'h00);

    // 6: no-init build
    rstBN = 1'b1;
    checkVal("b_pre_edge", {bReady, bInitDone}, 2'b00);
    step();
    checkVal("b_first_cycle", {bReady, bInitDone}, 2'b11);
    bValid = 1'b1; bWr = 1'b1; bAddr = 8'h40; bWdata = 8'h77;
    step();
    bValid = 1'b0;
    checkVal("b_wr_bus", {bCs0, bCs1, bRamWr, bWordAddr, bDataIn}, {3'b101, 7'h40, 8'h77});
    step();
    bValid = 1'b1; bWr = 1'b0; bAddr = 8'h40;
    step();
    bValid = 1'b0;
    checkVal("b_rd_busy", bReady, 1'b0);
    step();
    bValid = 1'b1; bWr = 1'b1; bAddr = 8'hC1; bWdata = 8'h5A;
    checkVal("b_resp_not_ready", bReady, 1'b0);
    step();
    checkVal("b_resp", {bRespValid, bRespRdata, bReady}, {1'b1, 8'h77, 1'b1});
    checkVal("b_idle_cs", {bCs0, bCs1, bRamWr}, 3'b000);
    step();
    checkVal("b_late_accept", {bCs0, bCs1, bRamWr, bWordAddr, bDataIn}, {3'b011, 7'h41, 8'h5A});
    bValid = 1'b0;
    step();
    checkVal("b_mem", memB1[7'h41], 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
